// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO LUT controller.
// Enabling QUARTER_WAVE_EN makes the blocks that import this package switch to quarter-wave playback.
package nco_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } nco_state_e;

  typedef logic [ADDR_W_DEF-1:0] lut_addr_t;
  typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator for the NCO. It holds the FCW and phase registers and turns the phase into a LUT address.
// With QUARTER_WAVE_EN defined, the phase is folded into a quarter-wave address plus a sign select.
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic               cfg_fcw_we,
  input  logic               clear,
  input  logic               advance,
  output logic [ADDR_W-1:0]  lut_addr
`ifdef QUARTER_WAVE_EN
  ,
  output logic               neg_sel
`endif
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;

  // Clear wins over advance so that entering playback always starts at phase 0.
  always_comb begin
    fcw_d   = cfg_fcw_we ? cfg_fcw : fcw_q;
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (advance) begin
      phase_d = phase_q + fcw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      fcw_q   <= '0;
    end else begin
      phase_q <= phase_d;
      fcw_q   <= fcw_d;
    end
  end

`ifdef QUARTER_WAVE_EN
  logic [1:0]        quad;
  logic [ADDR_W-1:0] idx;

  // Odd quadrants walk the quarter table backwards. The upper half of the cycle is negated downstream.
  always_comb begin
    quad     = phase_q[PHASE_W-1 -: 2];
    idx      = phase_q[PHASE_W-3 -: ADDR_W];
    lut_addr = quad[0] ? ~idx : idx;
    neg_sel  = quad[1];
  end
`else
  assign lut_addr = phase_q[PHASE_W-1 -: ADDR_W];
`endif

endmodule

// File: rtl/nco_lut_ctrl.sv
// NCO LUT controller. It streams a waveform table into the LUT RAM, then plays it back with one sample per clock.
// With QUARTER_WAVE_EN defined, the table holds a quarter sine and the sign is restored at the output.
module nco_lut_ctrl
  import nco_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic               cfg_fcw_we,
  input  logic               load_start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  input  logic               run_en,
  output logic               ram_csb0,
  output logic [ADDR_W-1:0]  ram_addr0,
  output logic [DATA_W-1:0]  ram_din0,
  output logic               ram_csb1,
  output logic [ADDR_W-1:0]  ram_addr1,
  input  logic [DATA_W-1:0]  ram_dout1,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_vld,
  output logic               table_loaded,
  output logic [1:0]         state
);

  nco_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              table_loaded_q, table_loaded_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              xfer;
  logic              phase_clear;
  logic              phase_adv;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] rd_sample;

`ifdef QUARTER_WAVE_EN
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic neg_sel;
  logic neg_q, neg_d;
`endif

  nco_phase_acc #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W)
  ) u_phase_acc (
    .clk        (clk),
    .rst        (rst),
    .cfg_fcw    (cfg_fcw),
    .cfg_fcw_we (cfg_fcw_we),
    .clear      (phase_clear),
    .advance    (phase_adv),
    .lut_addr   (lut_addr)
`ifdef QUARTER_WAVE_EN
    ,
    .neg_sel    (neg_sel)
`endif
  );

  // A read issued in RUN is delivered next cycle unless a new load is starting.
  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    table_loaded_d = table_loaded_q;
    rd_vld_d       = 1'b0;
    phase_clear    = 1'b0;
    phase_adv      = 1'b0;
    load_ready     = 1'b0;
    xfer           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d   = ST_LOAD;
          wr_addr_d = '0;
        end else if (run_en && table_loaded_q) begin
          state_d     = ST_RUN;
          phase_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        xfer       = load_valid;
        if (load_start) begin
          wr_addr_d = '0;
        end else if (xfer) begin
          wr_addr_d = wr_addr_q + 1'b1;
          if (load_last || (&wr_addr_q)) begin
            state_d        = ST_IDLE;
            table_loaded_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        phase_adv = 1'b1;
        if (load_start) begin
          state_d   = ST_LOAD;
          wr_addr_d = '0;
        end else begin
          rd_vld_d = 1'b1;
          if (!run_en) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ram_csb0  = ~xfer;
    ram_addr0 = (state_q == ST_LOAD) ? wr_addr_q : '0;
    ram_din0  = (state_q == ST_LOAD) ? load_data : '0;
    ram_csb1  = (state_q != ST_RUN);
    ram_addr1 = (state_q == ST_RUN) ? lut_addr : '0;
  end

  // RAM data arrives after the negedge, so the fresh sample is muxed straight out and captured for holding.
`ifdef QUARTER_WAVE_EN
  always_comb begin
    neg_d     = neg_sel;
    rd_sample = ram_dout1;
    if (neg_q) begin
      rd_sample = (ram_dout1 == S_MIN) ? S_MAX : -ram_dout1;
    end
  end
`else
  assign rd_sample = ram_dout1;
`endif

  always_comb begin
    sample_out = rd_vld_q ? rd_sample : sample_q;
    sample_d   = sample_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_addr_q      <= '0;
      table_loaded_q <= 1'b0;
      rd_vld_q       <= 1'b0;
      sample_q       <= '0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      table_loaded_q <= table_loaded_d;
      rd_vld_q       <= rd_vld_d;
      sample_q       <= sample_d;
    end
  end

`ifdef QUARTER_WAVE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`endif

  assign sample_vld   = rd_vld_q;
  assign table_loaded = table_loaded_q;
  assign state        = state_q;

endmodule

// File: tb/tb_nco_lut_ctrl.sv
// Self-checking bench for nco_lut_ctrl. It pairs a behavioural LUT RAM with an arithmetic reference model.
// The same bench covers QUARTER_WAVE_EN builds; the model folds the phase the same way when that macro is defined.
module tb_nco_lut_ctrl;
  import nco_pkg::*;

  typedef struct packed {
    logic        ls;
    logic        lv;
    logic        ll;
    logic [15:0] ld;
    logic [1:0]  e_state;
    logic        e_ready;
    logic        e_csb0;
    logic [7:0]  e_addr0;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_fcw = '0;
  logic        cfg_fcw_we = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [15:0] load_data = '0;
  logic        run_en = 1'b0;
  logic        load_ready, ram_csb0, ram_csb1, sample_vld, table_loaded;
  logic [7:0]  ram_addr0, ram_addr1;
  logic [15:0] ram_din0, sample_out;
  logic [15:0] ram_dout1 = '0;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail = 0;

  sample_t     ref_tab [256];
  sample_t     load_buf [256];
  vec_t        vecs [14];

  logic [15:0] mem [256] = '{default: 16'h5A5A};
  logic        cap_csb0 = 1'b1;
  logic        cap_csb1 = 1'b1;
  logic [7:0]  cap_a0 = '0;
  logic [7:0]  cap_a1 = '0;
  logic [15:0] cap_d0 = '0;

  always #5 clk = ~clk;

  nco_lut_ctrl #(.PHASE_W(32), .ADDR_W(8), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_fcw      (cfg_fcw),
    .cfg_fcw_we   (cfg_fcw_we),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_last    (load_last),
    .run_en       (run_en),
    .ram_csb0     (ram_csb0),
    .ram_addr0    (ram_addr0),
    .ram_din0     (ram_din0),
    .ram_csb1     (ram_csb1),
    .ram_addr1    (ram_addr1),
    .ram_dout1    (ram_dout1),
    .sample_out   (sample_out),
    .sample_vld   (sample_vld),
    .table_loaded (table_loaded),
    .state        (state)
  );

  // LUT RAM model: ports captured at posedge, array accessed at negedge.
  always @(posedge clk) begin
    cap_csb0 <= ram_csb0;
    cap_a0   <= ram_addr0;
    cap_d0   <= ram_din0;
    cap_csb1 <= ram_csb1;
    cap_a1   <= ram_addr1;
  end

  always @(negedge clk) begin
    if (!cap_csb0) mem[cap_a0] <= cap_d0;
    if (!cap_csb1) ram_dout1 <= mem[cap_a1];
  end

  function automatic lut_addr_t exp_addr(input logic [31:0] ph);
`ifdef QUARTER_WAVE_EN
    int quad, idx;
    quad = int'(ph >> 30);
    idx  = int'((ph >> 22) & 32'hFF);
    return (quad % 2 == 1) ? 8'(255 - idx) : 8'(idx);
`else
    return 8'(ph >> 24);
`endif
  endfunction

  function automatic sample_t exp_sample(input logic [31:0] ph);
    sample_t v;
    v = ref_tab[exp_addr(ph)];
`ifdef QUARTER_WAVE_EN
    if (ph >= 32'h8000_0000) v = (v == 16'h8000) ? 16'h7FFF : 16'h0000 - v;
`endif
    return v;
  endfunction

  function automatic vec_t mkvec(input logic ls, lv, ll, input logic [15:0] ld,
                                 input logic [1:0] es, input logic er, ec, input logic [7:0] ea);
    vec_t r;
    r.ls = ls; r.lv = lv; r.ll = ll; r.ld = ld;
    r.e_state = es; r.e_ready = er; r.e_csb0 = ec; r.e_addr0 = ea;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ls, lv, ll, input logic [15:0] ld,
                               input logic re, we, input logic [31:0] fcw);
    @(posedge clk);
    #1;
    load_start = ls; load_valid = lv; load_last = ll; load_data = ld;
    run_en = re; cfg_fcw_we = we; cfg_fcw = fcw;
    #6;
  endtask

  task automatic check_table(input string name);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_tab[i]) diffs++;
    checkOutput(name, diffs, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_load_ready"}, load_ready, 0);
    checkOutput({tag, "_csb0"}, ram_csb0, 1);
    checkOutput({tag, "_addr0"}, ram_addr0, 0);
    checkOutput({tag, "_din0"}, ram_din0, 0);
    checkOutput({tag, "_csb1"}, ram_csb1, 1);
    checkOutput({tag, "_addr1"}, ram_addr1, 0);
    checkOutput({tag, "_sample_out"}, sample_out, 0);
    checkOutput({tag, "_sample_vld"}, sample_vld, 0);
    checkOutput({tag, "_table_loaded"}, table_loaded, 0);
  endtask

  task automatic load_words(input int n, input bit use_last, input bit gaps);
    int low_cnt, errs;
    low_cnt = 0;
    errs = 0;
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 32'h0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        applyStimulus(0, 0, 0, 16'($urandom), 0, 0, 32'h0);
        if (ram_csb0 !== 1'b1 || load_ready !== 1'b1) errs++;
      end
      applyStimulus(0, 1, use_last && (i == n - 1), load_buf[i], 0, 0, 32'h0);
      if (ram_csb0 === 1'b0) low_cnt++;
      if (ram_addr0 !== 8'(i) || ram_din0 !== load_buf[i] || load_ready !== 1'b1) errs++;
      ref_tab[i] = load_buf[i];
    end
    applyStimulus(0, 0, 0, 16'h0, 0, 0, 32'h0);
    checkOutput("load_wr_cycles", low_cnt, n);
    checkOutput("load_addr_data", errs, 0);
    checkOutput("load_done_state", state, 0);
    checkOutput("load_done_csb0", ram_csb0, 1);
    checkOutput("load_table_loaded", table_loaded, 1);
    check_table("load_table");
  endtask

  task automatic play(input logic [31:0] fcw0, input int n, input int chg_at,
                      input logic [31:0] fcw1, input bit interrupt);
    logic [31:0] ph, cur;
    sample_t     exp_s, last_s;
    bit          have;
    applyStimulus(0, 0, 0, 16'h0, 0, 1, fcw0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0, fcw0);
    checkOutput("run_entry_state", state, 0);
    checkOutput("run_entry_csb1", ram_csb1, 1);
    ph = '0;
    cur = fcw0;
    have = 0;
    exp_s = '0;
    last_s = '0;
    for (int j = 1; j <= n; j++) begin
      logic we, re, ls;
      we = (j == chg_at);
      re = (j < n) || interrupt;
      ls = interrupt && (j == n);
      applyStimulus(ls, 0, 0, 16'h0, re, we, we ? fcw1 : fcw0);
      checkOutput("run_state", state, 2);
      checkOutput("run_csb1", ram_csb1, 0);
      checkOutput("run_rd_addr", ram_addr1, exp_addr(ph));
      checkOutput("run_vld", sample_vld, have);
      if (have) begin
        checkOutput("run_sample", sample_out, exp_s);
        last_s = exp_s;
      end
      exp_s = exp_sample(ph);
      have = 1;
      ph = ph + cur;
      if (we) cur = fcw1;
    end
    applyStimulus(0, 0, 0, 16'h0, 0, 0, 32'h0);
    if (interrupt) begin
      checkOutput("intr_state", state, 1);
      checkOutput("intr_vld", sample_vld, 0);
      checkOutput("intr_csb1", ram_csb1, 1);
      checkOutput("intr_sample_hold", sample_out, last_s);
    end else begin
      checkOutput("stop_state", state, 0);
      checkOutput("stop_vld", sample_vld, 1);
      checkOutput("stop_sample", sample_out, exp_s);
      applyStimulus(0, 0, 0, 16'h0, 0, 0, 32'h0);
      checkOutput("stop_vld_after", sample_vld, 0);
      checkOutput("stop_sample_hold", sample_out, exp_s);
      checkOutput("stop_csb1", ram_csb1, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic [31:0] rf0, rf1;
    int          rn, rc;

    for (int i = 0; i < 256; i++) ref_tab[i] = 16'h5A5A;

    repeat (3) applyStimulus(0, 0, 0, 16'h0, 0, 0, 32'h0);
    check_reset_vals("reset");
    rst = 1'b0;

    // Full ramp load ending on address 255 without load_last
    for (int i = 0; i < 256; i++) load_buf[i] = 16'(i * 3);
    load_words(256, 0, 0);

    // Playback at one address per cycle, spanning the wrap after 255
    play(32'h0100_0000, 300, 0, 32'h0, 0);

    // Early load_last: ten words with gaps and an ignored last-without-valid
    vecs[0]  = mkvec(1, 0, 0, 16'd0,     2'd0, 0, 1, 8'd0);
    vecs[1]  = mkvec(0, 1, 0, 16'd100,   2'd1, 1, 0, 8'd0);
    vecs[2]  = mkvec(0, 0, 0, 16'hBEEF,  2'd1, 1, 1, 8'd1);
    vecs[3]  = mkvec(0, 1, 0, 16'd101,   2'd1, 1, 0, 8'd1);
    vecs[4]  = mkvec(0, 1, 0, 16'd102,   2'd1, 1, 0, 8'd2);
    vecs[5]  = mkvec(0, 1, 0, 16'd103,   2'd1, 1, 0, 8'd3);
    vecs[6]  = mkvec(0, 0, 1, 16'h1234,  2'd1, 1, 1, 8'd4);
    vecs[7]  = mkvec(0, 1, 0, 16'd104,   2'd1, 1, 0, 8'd4);
    vecs[8]  = mkvec(0, 1, 0, 16'd105,   2'd1, 1, 0, 8'd5);
    vecs[9]  = mkvec(0, 1, 0, 16'd106,   2'd1, 1, 0, 8'd6);
    vecs[10] = mkvec(0, 1, 0, 16'd107,   2'd1, 1, 0, 8'd7);
    vecs[11] = mkvec(0, 1, 0, 16'd108,   2'd1, 1, 0, 8'd8);
    vecs[12] = mkvec(0, 1, 1, 16'd109,   2'd1, 1, 0, 8'd9);
    vecs[13] = mkvec(0, 0, 0, 16'd0,     2'd0, 0, 1, 8'd0);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(vecs[k].ls, vecs[k].lv, vecs[k].ll, vecs[k].ld, 0, 0, 32'h0);
      checkOutput("vec_state", state, vecs[k].e_state);
      checkOutput("vec_ready", load_ready, vecs[k].e_ready);
      checkOutput("vec_csb0", ram_csb0, vecs[k].e_csb0);
      checkOutput("vec_addr0", ram_addr0, vecs[k].e_addr0);
      checkOutput("vec_din0", ram_din0, (vecs[k].e_state == 2'd1) ? vecs[k].ld : 16'h0);
    end
    for (int i = 0; i < 10; i++) ref_tab[i] = 16'(100 + i);
    check_table("early_last_table");
    checkOutput("early_last_loaded", table_loaded, 1);

    // Random table (with the most negative word present) and random playback runs
    for (int i = 0; i < 256; i++) load_buf[i] = 16'($urandom);
    load_buf[17] = 16'h8000;
    load_words(256, 0, 1);
    for (int r = 0; r < 6; r++) begin
      rf0 = $urandom;
      rf1 = $urandom;
      rn  = $urandom_range(3, 40);
      rc  = $urandom_range(0, rn);
      play(rf0, rn, rc, rf1, 0);
    end

`ifdef QUARTER_WAVE_EN
    for (int i = 0; i < 256; i++) load_buf[i] = 16'(i + 1);
    load_buf[3] = 16'h8000;
    load_words(256, 0, 0);
    play(32'h0040_0000, 1030, 0, 32'h0, 0);
`endif

    // Load request during playback, then reset after five words of the new load
    play(32'h0100_0000, 6, 0, 32'h0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 16'(500 + i), 0, 0, 32'h0);
      checkOutput("midload_addr0", ram_addr0, i);
      ref_tab[i] = 16'(500 + i);
    end
    rst = 1'b1;
    applyStimulus(0, 1, 0, 16'hEEEE, 1, 0, 32'h0);
    check_reset_vals("midload_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 16'h0, 1, 0, 32'h0);
      checkOutput("rst_run_ign_state", state, 0);
      checkOutput("rst_run_ign_csb1", ram_csb1, 1);
      checkOutput("rst_run_ign_vld", sample_vld, 0);
    end
    check_table("partial_table");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
